// File: rtl/beam_sweep_scheduler_pkg.sv
// Shared types for the beam sweep scheduler: beam table entry layout and FSM states.
package beam_sweep_scheduler_pkg;

  localparam int ANGLE_W = 16;

  typedef struct packed {
    logic               is_tx;
    logic [ANGLE_W-1:0] el_deg;
    logic [ANGLE_W-1:0] az_deg;
  } beam_entry_t;

  localparam int ENTRY_W = $bits(beam_entry_t);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DWELL = 3'd5
  } sched_state_e;

endpackage

// File: rtl/beam_sweep_scheduler_ram.sv
// Beam position table: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module beam_sweep_scheduler_ram
  import beam_sweep_scheduler_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  beam_entry_t   wdata,
  input  logic [AW-1:0] raddr,
  output beam_entry_t   rdata
);

  beam_entry_t mem_r [DEPTH];

  // Table write and read-first registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/beam_sweep_scheduler.sv
// Steps beamformer_top through a range of the beam table: load angles, pulse start,
// gather per-lane done, dwell, advance; supports looping, abort and a WAIT timeout.
module beam_sweep_scheduler
  import beam_sweep_scheduler_pkg::*;
#(
  parameter int NUM_SPI  = 8,
  parameter int DEPTH    = 64,
  parameter int TIMEOUT  = 65535,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  input  logic               sweep_start,
  input  logic [AW-1:0]      sweep_first,
  input  logic [AW-1:0]      sweep_last,
  input  logic               sweep_loop,
  input  logic [15:0]        dwell_cycles,
  input  logic               abort,
  output logic               bf_start,
  output logic               bf_isTX,
  output logic [ANGLE_W-1:0] bf_az_deg,
  output logic [ANGLE_W-1:0] bf_el_deg,
  input  logic [NUM_SPI-1:0] bf_busy,
  input  logic [NUM_SPI-1:0] bf_done,
  output logic               sweep_busy,
  output logic [AW-1:0]      beam_idx,
  output logic               beam_strobe,
  output logic               sweep_done,
  output logic               timeout_err
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  sched_state_e       state_r, state_s, adv_state_s;
  logic [AW-1:0]      idx_r, first_r, last_r, idx_next_s;
  logic               loop_r;
  logic [15:0]        dwell_r, dwell_cnt_r;
  logic [TW-1:0]      tmo_cnt_r;
  logic [NUM_SPI-1:0] mask_r, mask_s;
  logic               abort_pend_r, abort_s;
  logic               start_ok_s, last_hit_s, advance_s, tmo_hit_s, load_s;
  beam_entry_t        rd_data_s;
  logic               unused_busy_s;

  beam_sweep_scheduler_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (beam_entry_t'(cfg_wdata)),
    .raddr (idx_r),
    .rdata (rd_data_s)
  );

  // A pending abort acts in the same cycle it arrives as well as later
  assign start_ok_s    = (state_r == ST_IDLE) && sweep_start;
  assign abort_s       = abort | abort_pend_r;
  assign mask_s        = mask_r | bf_done;
  assign last_hit_s    = (idx_r == last_r);
  assign idx_next_s    = last_hit_s ? first_r : idx_r + AW'(1);
  assign adv_state_s   = (last_hit_s && !loop_r) ? ST_IDLE : ST_RD;
  assign load_s        = (state_r == ST_LATCH) && !abort_s;
  assign unused_busy_s = ^bf_busy;

  // Next-state logic; advance_s marks the end-of-beam index decision
  always_comb begin
    state_s   = state_r;
    advance_s = 1'b0;
    tmo_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sweep_start) state_s = ST_RD;
        else             state_s = ST_IDLE;
      end
      ST_RD: begin
        if (abort_s) state_s = ST_IDLE;
        else         state_s = ST_LATCH;
      end
      ST_LATCH: begin
        if (abort_s) state_s = ST_IDLE;
        else         state_s = ST_ISSUE;
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (&mask_s) begin
          if (abort_s) begin
            state_s = ST_IDLE;
          end else if (dwell_r == 16'd0) begin
            advance_s = 1'b1;
            state_s   = adv_state_s;
          end else begin
            state_s = ST_DWELL;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_hit_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DWELL: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else if (dwell_cnt_r == dwell_r - 16'd1) begin
          advance_s = 1'b1;
          state_s   = adv_state_s;
        end else begin
          state_s = ST_DWELL;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, sampled sweep config, beam index, done mask and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      first_r      <= '0;
      last_r       <= '0;
      loop_r       <= 1'b0;
      dwell_r      <= 16'd0;
      dwell_cnt_r  <= 16'd0;
      tmo_cnt_r    <= '0;
      mask_r       <= '0;
      abort_pend_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_ok_s) begin
        idx_r   <= sweep_first;
        first_r <= sweep_first;
        last_r  <= sweep_last;
        loop_r  <= sweep_loop;
        dwell_r <= dwell_cycles;
      end else if (advance_s) begin
        idx_r <= idx_next_s;
      end
      if (state_r == ST_ISSUE) begin
        mask_r    <= '0;
        tmo_cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
        mask_r    <= mask_s;
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
      if (state_r == ST_DWELL) dwell_cnt_r <= dwell_cnt_r + 16'd1;
      else                     dwell_cnt_r <= 16'd0;
      // Aborts seen in IDLE (including alongside a start) are dropped
      if ((state_r == ST_IDLE) || (state_s == ST_IDLE)) abort_pend_r <= 1'b0;
      else                                               abort_pend_r <= abort_pend_r | abort;
    end
  end

  // Registered outputs toward beamformer_top and the host
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_start    <= 1'b0;
      bf_isTX     <= 1'b0;
      bf_az_deg   <= '0;
      bf_el_deg   <= '0;
      sweep_busy  <= 1'b0;
      beam_idx    <= '0;
      beam_strobe <= 1'b0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      bf_start    <= (state_r == ST_ISSUE);
      beam_strobe <= load_s;
      if (load_s) begin
        bf_isTX   <= rd_data_s.is_tx;
        bf_az_deg <= rd_data_s.az_deg;
        bf_el_deg <= rd_data_s.el_deg;
        beam_idx  <= idx_r;
      end
      sweep_busy <= (state_s != ST_IDLE);
      sweep_done <= (state_r != ST_IDLE) && (state_s == ST_IDLE);
      if (start_ok_s)     timeout_err <= 1'b0;
      else if (tmo_hit_s) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Randomized self-checking bench for beam_sweep_scheduler against a cycle-timed
// reference model of beam order, start/strobe/done timing, abort and timeout rules.
module tb_beam_sweep_scheduler;

  localparam int NUM_SPI = 8;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [5:0]   cfg_addr;
  logic [32:0]  cfg_wdata;
  logic         sweep_start;
  logic [5:0]   sweep_first, sweep_last;
  logic         sweep_loop;
  logic [15:0]  dwell_cycles;
  logic         abort;
  logic         bf_start, bf_isTX;
  logic [15:0]  bf_az_deg, bf_el_deg;
  logic [7:0]   bf_busy, bf_done;
  logic         sweep_busy;
  logic [5:0]   beam_idx;
  logic         beam_strobe, sweep_done, timeout_err;

  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [32:0]  shadow [DEPTH];

  typedef struct {
    int first;
    int last;
    bit loop;
    int dwell;
    int abort_beam;
    int abort_dwell_beam;
    int stuck_lane;
    bit rf;
    bit abort_start;
    int done_fix;
  } sweep_cfg_t;

  beam_sweep_scheduler #(
    .NUM_SPI (NUM_SPI),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .sweep_start  (sweep_start),
    .sweep_first  (sweep_first),
    .sweep_last   (sweep_last),
    .sweep_loop   (sweep_loop),
    .dwell_cycles (dwell_cycles),
    .abort        (abort),
    .bf_start     (bf_start),
    .bf_isTX      (bf_isTX),
    .bf_az_deg    (bf_az_deg),
    .bf_el_deg    (bf_el_deg),
    .bf_busy      (bf_busy),
    .bf_done      (bf_done),
    .sweep_busy   (sweep_busy),
    .beam_idx     (beam_idx),
    .beam_strobe  (beam_strobe),
    .sweep_done   (sweep_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic write_entry(input int addr, input logic [32:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 6'(addr);
    cfg_wdata = data;
    shadow[addr] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  function automatic sweep_cfg_t base_cfg(input int first, input int last, input int dwell);
    sweep_cfg_t c;
    c = '{default: 0};
    c.first      = first;
    c.last       = last;
    c.dwell      = dwell;
    c.stuck_lane = -1;
    return c;
  endfunction

  // Runs one sweep; every cycle compares start/strobe/done/busy/error against model timing
  task automatic run_sweep(input sweep_cfg_t c);
    int          exp_start, exp_done, abort_cyc, start_cyc, n_beam, idx;
    bit          aborted, beam_active, ended;
    logic [7:0]  seen;
    int          due [NUM_SPI];
    logic [32:0] rf_new;

    rf_new[31:0] = $urandom;
    rf_new[32]   = 1'($urandom_range(0, 1));
    @(negedge clk);
    sweep_first  = 6'(c.first);
    sweep_last   = 6'(c.last);
    sweep_loop   = c.loop;
    dwell_cycles = 16'(c.dwell);
    sweep_start  = 1'b1;
    abort        = c.abort_start;
    start_cyc    = cyc;
    exp_start    = cyc + 4;
    exp_done     = -1;
    abort_cyc    = -1;
    idx          = c.first;
    n_beam       = 0;
    aborted      = 1'b0;
    beam_active  = 1'b0;
    ended        = 1'b0;
    seen         = 8'h00;
    for (int l = 0; l < NUM_SPI; l++) due[l] = -1;

    for (int step = 0; step < 4000 && !ended; step++) begin
      @(negedge clk);
      sweep_start = 1'b0;
      abort       = 1'b0;
      cfg_we      = 1'b0;
      bf_done     = 8'h00;
      check_val("bf_start", bf_start, cyc == exp_start);
      check_val("beam_strobe", beam_strobe, cyc == exp_start - 1);
      check_val("sweep_done", sweep_done, cyc == exp_done);
      check_val("sweep_busy", sweep_busy, cyc != exp_done);
      check_val("timeout_err", timeout_err, (cyc == exp_done) && (c.stuck_lane >= 0));
      if (cyc == exp_start) begin
        check_val("beam_idx", beam_idx, idx);
        check_val("bf_entry", {bf_isTX, bf_el_deg, bf_az_deg}, shadow[idx]);
        if (c.rf && n_beam == 0) shadow[c.first] = rf_new;
        n_beam++;
        beam_active = 1'b1;
        seen        = 8'h00;
        exp_start   = -1;
        for (int l = 0; l < NUM_SPI; l++) begin
          if (l == c.stuck_lane) due[l] = -1;
          else if (c.done_fix > 0) due[l] = cyc + c.done_fix;
          else due[l] = cyc + $urandom_range(2, 25);
        end
        if (c.stuck_lane >= 0) exp_done = cyc + TIMEOUT;
        if (n_beam == c.abort_beam) begin
          abort_cyc = cyc + 1;
          aborted   = 1'b1;
        end
      end
      if (cyc == exp_done) begin
        ended = 1'b1;
      end else begin
        if (c.rf && cyc == start_cyc + 1) begin
          cfg_we    = 1'b1;
          cfg_addr  = 6'(c.first);
          cfg_wdata = rf_new;
        end
        if (cyc == abort_cyc) abort = 1'b1;
        for (int l = 0; l < NUM_SPI; l++) begin
          if (due[l] == cyc) begin
            bf_done[l] = 1'b1;
            seen[l]    = 1'b1;
            due[l]     = ($urandom_range(0, 3) == 0) ? cyc + 1 : -1;
          end
        end
        if (beam_active && seen == 8'hFF) begin
          beam_active = 1'b0;
          if (aborted) begin
            exp_done = cyc + 1;
          end else if (c.abort_dwell_beam == n_beam && c.dwell > 0) begin
            abort_cyc = cyc + 1;
            exp_done  = cyc + 2;
          end else if (idx == c.last && !c.loop) begin
            exp_done = cyc + c.dwell + 1;
          end else begin
            idx       = (idx == c.last) ? c.first : (idx + 1) % DEPTH;
            exp_start = cyc + c.dwell + 4;
          end
        end
        if ($urandom_range(0, 9) == 0) begin
          sweep_start  = 1'b1;
          sweep_first  = 6'($urandom);
          sweep_last   = 6'($urandom);
          sweep_loop   = 1'($urandom);
          dwell_cycles = 16'($urandom_range(0, 9));
        end
      end
    end
    if (!ended) check_val("sweep_end_budget", 0, 1);
    // Abort while idle must be ignored; timeout_err must stay sticky
    @(negedge clk);
    sweep_start = 1'b0;
    bf_done     = 8'h00;
    abort       = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("idle_after_sweep", {sweep_busy, bf_start, sweep_done}, 3'b000);
    check_val("timeout_sticky", timeout_err, c.stuck_lane >= 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sweep_cfg_t c;
    logic [32:0] rnd;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_wdata = 33'd0;
    sweep_start = 1'b0; sweep_first = 6'd0; sweep_last = 6'd0; sweep_loop = 1'b0;
    dwell_cycles = 16'd0; abort = 1'b0; bf_busy = 8'h00; bf_done = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_outputs",
              {bf_start, bf_isTX, bf_az_deg, bf_el_deg, sweep_busy, beam_idx, beam_strobe, sweep_done, timeout_err},
              44'd0);

    for (int a = 0; a < DEPTH; a++) begin
      rnd[31:0] = $urandom;
      rnd[32]   = 1'($urandom_range(0, 1));
      write_entry(a, rnd);
    end
    // 10/20/30 degrees az, 0/5/-5 degrees el in Q9.7
    write_entry(0, {1'b1, 16'h0000, 16'h0500});
    write_entry(1, {1'b0, 16'h0280, 16'h0A00});
    write_entry(2, {1'b1, 16'hFD80, 16'h0F00});

    c = base_cfg(0, 2, 4); c.done_fix = 20;                  run_sweep(c);
    c = base_cfg(62, 1, 1);                                  run_sweep(c);
    c = base_cfg(5, 6, 2); c.loop = 1'b1; c.abort_beam = 3;  run_sweep(c);
    c = base_cfg(10, 12, 0); c.stuck_lane = 5;               run_sweep(c);
    c = base_cfg(20, 23, 0);                                 run_sweep(c);
    c = base_cfg(40, 40, 3); c.rf = 1'b1; c.abort_start = 1'b1; run_sweep(c);
    c = base_cfg(30, 34, 3); c.abort_dwell_beam = 2;         run_sweep(c);

    for (int n = 0; n < 6; n++) begin
      c = base_cfg($urandom_range(0, 63), 0, $urandom_range(0, 6));
      c.last             = (c.first + $urandom_range(0, 5)) % DEPTH;
      c.loop             = 1'($urandom_range(0, 1));
      c.abort_beam       = c.loop ? $urandom_range(1, 8) : $urandom_range(0, 4);
      c.abort_dwell_beam = $urandom_range(0, 3);
      c.abort_start      = 1'($urandom_range(0, 1));
      run_sweep(c);
    end

    // Reset in the middle of WAIT
    @(negedge clk);
    sweep_first = 6'd3; sweep_last = 6'd3; sweep_loop = 1'b1; dwell_cycles = 16'd0;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int i = 0; i < 10 && !bf_start; i++) @(negedge clk);
    check_val("t6_bf_start", bf_start, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t6_reset_outputs",
              {bf_start, bf_isTX, bf_az_deg, bf_el_deg, sweep_busy, beam_idx, beam_strobe, sweep_done, timeout_err},
              44'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t6_quiet", {sweep_done, sweep_busy, bf_start}, 3'b000);
    end
    write_entry(3, {1'b1, 16'h1234, 16'h0ABC});
    write_entry(4, {1'b0, 16'hF000, 16'h0101});
    c = base_cfg(3, 4, 2); run_sweep(c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
